execstage: RTL and testbench

//  Execute stage of the 5-stage RV32I pipeline, directly downstream of the decode stage.
//  - Captures decode outputs (func, left, right, extra, rd, rdv) in a stage register.
//  - Computes the ALU result, resolves branches and jumps, and drives jmp/jmp_target back to fetch and decode.
//  - Performs SLL/SRL/SRA iteratively, one bit per cycle, and stalls upstream with busy while doing so.

---
 rtl/execstage_pkg.sv | 61 ++++++
 rtl/execstage_serial_shifter.sv | 72 +++++++
 rtl/execstage.sv | 134 +++++++++++++
 tb/tb_execstage.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/execstage_pkg.sv
// Shared opcode encoding, widths and shift helpers for the RV32I execute stage.
package execstage_pkg;

  localparam int unsigned FUNC_W  = 6;
  localparam int unsigned RD_W    = 5;
  localparam int unsigned SHAMT_W = 5;

  localparam logic [FUNC_W-1:0] OP_NOP   = 6'd0;
  localparam logic [FUNC_W-1:0] OP_ADD   = 6'd1;
  localparam logic [FUNC_W-1:0] OP_ADDI  = 6'd2;
  localparam logic [FUNC_W-1:0] OP_SUB   = 6'd3;
  localparam logic [FUNC_W-1:0] OP_SLT   = 6'd4;
  localparam logic [FUNC_W-1:0] OP_SLTI  = 6'd5;
  localparam logic [FUNC_W-1:0] OP_SLTU  = 6'd6;
  localparam logic [FUNC_W-1:0] OP_SLTIU = 6'd7;
  localparam logic [FUNC_W-1:0] OP_XOR   = 6'd8;
  localparam logic [FUNC_W-1:0] OP_XORI  = 6'd9;
  localparam logic [FUNC_W-1:0] OP_OR    = 6'd10;
  localparam logic [FUNC_W-1:0] OP_ORI   = 6'd11;
  localparam logic [FUNC_W-1:0] OP_AND   = 6'd12;
  localparam logic [FUNC_W-1:0] OP_ANDI  = 6'd13;
  localparam logic [FUNC_W-1:0] OP_SLL   = 6'd14;
  localparam logic [FUNC_W-1:0] OP_SLLI  = 6'd15;
  localparam logic [FUNC_W-1:0] OP_SRL   = 6'd16;
  localparam logic [FUNC_W-1:0] OP_SRLI  = 6'd17;
  localparam logic [FUNC_W-1:0] OP_SRA   = 6'd18;
  localparam logic [FUNC_W-1:0] OP_SRAI  = 6'd19;
  localparam logic [FUNC_W-1:0] OP_LUI   = 6'd20;
  localparam logic [FUNC_W-1:0] OP_AUIPC = 6'd21;
  localparam logic [FUNC_W-1:0] OP_JAL   = 6'd22;
  localparam logic [FUNC_W-1:0] OP_JALR  = 6'd23;
  localparam logic [FUNC_W-1:0] OP_BEQ   = 6'd24;
  localparam logic [FUNC_W-1:0] OP_BNE   = 6'd25;
  localparam logic [FUNC_W-1:0] OP_BLT   = 6'd26;
  localparam logic [FUNC_W-1:0] OP_BGE   = 6'd27;
  localparam logic [FUNC_W-1:0] OP_BLTU  = 6'd28;
  localparam logic [FUNC_W-1:0] OP_BGEU  = 6'd29;
  localparam logic [FUNC_W-1:0] OP_LB    = 6'd30;
  localparam logic [FUNC_W-1:0] OP_LH    = 6'd31;
  localparam logic [FUNC_W-1:0] OP_LW    = 6'd32;
  localparam logic [FUNC_W-1:0] OP_LBU   = 6'd33;
  localparam logic [FUNC_W-1:0] OP_LHU   = 6'd34;
  localparam logic [FUNC_W-1:0] OP_SB    = 6'd35;
  localparam logic [FUNC_W-1:0] OP_SH    = 6'd36;
  localparam logic [FUNC_W-1:0] OP_SW    = 6'd37;

  typedef enum logic [1:0] {SH_SLL, SH_SRL, SH_SRA} sh_op_e;

  function automatic logic shift_op(input logic [FUNC_W-1:0] f);
    return (f >= OP_SLL) && (f <= OP_SRAI);
  endfunction

  function automatic sh_op_e shift_kind(input logic [FUNC_W-1:0] f);
    case (f)
      OP_SLL, OP_SLLI: return SH_SLL;
      OP_SRL, OP_SRLI: return SH_SRL;
      default:         return SH_SRA;
    endcase
  endfunction

endpackage

// File: rtl/execstage_serial_shifter.sv
// Iterative one-bit-per-cycle shifter. The start cycle applies the first shift,
// so an n-bit shift holds busy for n cycles and presents its result the cycle after.
module serial_shifter
  import execstage_pkg::*;
#(
  parameter int unsigned width = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [width-1:0]   val,
  input  logic [SHAMT_W-1:0] amt,
  output logic               busy,
  output logic               done,
  output logic [width-1:0]   out
);

  typedef enum logic {S_IDLE, S_SHIFT} state_e;

  state_e               state_q;
  logic [width-1:0]     sh_val_q;
  logic [SHAMT_W-1:0]   sh_cnt_q;
  logic                 done_q;
  logic                 go;

  function automatic logic [width-1:0] shift1(input logic [width-1:0] v, input logic [1:0] o);
    case (o)
      2'(SH_SLL): return {v[width-2:0], 1'b0};
      2'(SH_SRL): return {1'b0, v[width-1:1]};
      default:    return {v[width-1], v[width-1:1]};
    endcase
  endfunction

  // done_q blocks a restart while the finished result is still on display
  assign go   = start & ~done_q;
  assign busy = (state_q == S_SHIFT) | go;
  assign done = done_q;
  assign out  = sh_val_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sh_val_q <= '0;
      sh_cnt_q <= '0;
      done_q   <= 1'b0;
    end else if (en) begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (go) begin
            sh_val_q <= shift1(val, op);
            sh_cnt_q <= amt - SHAMT_W'(1);
            if (amt == SHAMT_W'(1)) done_q  <= 1'b1;
            else                    state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          sh_val_q <= shift1(sh_val_q, op);
          sh_cnt_q <= sh_cnt_q - SHAMT_W'(1);
          if (sh_cnt_q == SHAMT_W'(1)) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/execstage.sv
// RV32I execute stage: stage register, inline ALU / branch resolution,
// and an iterative shifter that stalls upstream while it runs.
module execstage
  import execstage_pkg::*;
#(
  parameter int unsigned width = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FUNC_W-1:0] func_in,
  input  logic [width-1:0]  left,
  input  logic [width-1:0]  right,
  input  logic [width-1:0]  extra,
  input  logic [RD_W-1:0]   rd_in,
  input  logic              rdv_in,
  input  logic              stall_in,
  output logic              busy,
  output logic              jmp,
  output logic [width-1:0]  jmp_target,
  output logic [width-1:0]  result,
  output logic [FUNC_W-1:0] func_out,
  output logic [RD_W-1:0]   rd_out,
  output logic              rdv_out
);

  logic [FUNC_W-1:0] func_q;
  logic [width-1:0]  left_q, right_q, extra_q;
  logic [RD_W-1:0]   rd_q;
  logic              rdv_q;

  logic [width-1:0]  a, b, sum, diff, res, tgt, sh_out;
  logic              lt_s, lt_u, eq, taken, wr, valid_op;
  logic              sh_start, sh_busy, sh_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      func_q  <= OP_NOP;
      left_q  <= '0;
      right_q <= '0;
      extra_q <= '0;
      rd_q    <= '0;
      rdv_q   <= 1'b0;
    end else if (~stall_in & ~sh_busy) begin
      func_q  <= func_in;
      left_q  <= left;
      right_q <= right;
      extra_q <= extra;
      rd_q    <= rd_in;
      rdv_q   <= rdv_in;
    end
  end

  assign a    = right_q;
  assign b    = left_q;
  assign sum  = a + b;
  assign diff = a - b;
  assign lt_s = $signed(a) < $signed(b);
  assign lt_u = a < b;
  assign eq   = (a == b);

  assign sh_start = shift_op(func_q) & (b[SHAMT_W-1:0] != '0);

  serial_shifter #(.width(width)) u_shifter (
    .clk   (clk),
    .rst   (rst),
    .en    (~stall_in),
    .start (sh_start),
    .op    (2'(shift_kind(func_q))),
    .val   (a),
    .amt   (b[SHAMT_W-1:0]),
    .busy  (sh_busy),
    .done  (sh_done),
    .out   (sh_out)
  );

  always_comb begin
    res      = '0;
    tgt      = '0;
    taken    = 1'b0;
    wr       = rdv_q;
    valid_op = 1'b1;
    case (func_q)
      OP_ADD, OP_ADDI, OP_AUIPC,
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
      OP_SB, OP_SH, OP_SW:  res = sum;
      OP_SUB:               res = diff;
      OP_SLT, OP_SLTI:      res = width'(lt_s);
      OP_SLTU, OP_SLTIU:    res = width'(lt_u);
      OP_XOR, OP_XORI:      res = a ^ b;
      OP_OR, OP_ORI:        res = a | b;
      OP_AND, OP_ANDI:      res = a & b;
      OP_SLL, OP_SLLI, OP_SRL, OP_SRLI,
      OP_SRA, OP_SRAI:      res = sh_done ? sh_out : a;
      OP_LUI:               res = extra_q;
      OP_JAL: begin
        res   = extra_q;
        taken = 1'b1;
        tgt   = sum;
      end
      OP_JALR: begin
        res   = extra_q;
        taken = 1'b1;
        tgt   = sum & ~width'(1);
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        wr  = 1'b0;
        tgt = extra_q;
        case (func_q)
          OP_BEQ:  taken = eq;
          OP_BNE:  taken = ~eq;
          OP_BLT:  taken = lt_s;
          OP_BGE:  taken = ~lt_s;
          OP_BLTU: taken = lt_u;
          default: taken = ~lt_u;
        endcase
      end
      OP_NOP:  wr = 1'b0;
      default: begin
        wr       = 1'b0;
        valid_op = 1'b0;
      end
    endcase
  end

  // a busy shifter sends bubbles downstream; jmp never repeats across a freeze
  assign busy       = sh_busy;
  assign jmp        = taken & ~stall_in;
  assign jmp_target = tgt;
  assign result     = res;
  assign func_out   = (sh_busy | ~valid_op) ? OP_NOP : func_q;
  assign rd_out     = rd_q;
  assign rdv_out    = wr & ~sh_busy;

endmodule

// File: tb/tb_execstage.sv
// Self-checking bench for execstage: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the stage.
module tb_execstage;
  import execstage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  func_in = OP_NOP;
  logic [31:0] left = '0, right = '0, extra = '0;
  logic [4:0]  rd_in = '0;
  logic        rdv_in = 1'b0, stall_in = 1'b0;
  logic        busy, jmp, rdv_out;
  logic [31:0] jmp_target, result;
  logic [5:0]  func_out;
  logic [4:0]  rd_out;

  int n_checks = 0;
  int n_errors = 0;
  bit check_en = 1'b0;

  // model: instruction held in the stage and unstalled cycles it has spent there
  logic [5:0]  m_f = OP_NOP;
  logic [31:0] m_a = '0, m_b = '0, m_x = '0;
  logic [4:0]  m_rd = '0;
  logic        m_rdv = 1'b0;
  int          m_k = 0;

  typedef struct packed {
    logic        busy;
    logic        taken;
    logic        rdv;
    logic [5:0]  fo;
    logic [31:0] res;
    logic [31:0] tgt;
  } exp_t;

  always #5 clk = ~clk;

  execstage #(.width(32)) dut (
    .clk(clk), .rst(rst), .func_in(func_in), .left(left), .right(right),
    .extra(extra), .rd_in(rd_in), .rdv_in(rdv_in), .stall_in(stall_in),
    .busy(busy), .jmp(jmp), .jmp_target(jmp_target), .result(result),
    .func_out(func_out), .rd_out(rd_out), .rdv_out(rdv_out)
  );

  function automatic exp_t predict(input logic [5:0] f, input logic [31:0] a, b, x,
                                   input logic rdv, input int k);
    exp_t e;
    int   n;
    e    = '0;
    e.fo = OP_NOP;
    n    = int'(b[4:0]);
    if (f >= OP_ADD && f <= OP_SW) begin
      e.fo  = f;
      e.rdv = rdv;
    end
    case (f)
      OP_ADD, OP_ADDI, OP_AUIPC, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
      OP_SB, OP_SH, OP_SW:  e.res = a + b;
      OP_SUB:               e.res = a - b;
      OP_SLT, OP_SLTI:      e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU, OP_SLTIU:    e.res = (a < b) ? 32'd1 : 32'd0;
      OP_XOR, OP_XORI:      e.res = a ^ b;
      OP_OR, OP_ORI:        e.res = a | b;
      OP_AND, OP_ANDI:      e.res = a & b;
      OP_SLL, OP_SLLI: begin e.res = a << n;                 e.busy = (k < n); end
      OP_SRL, OP_SRLI: begin e.res = a >> n;                 e.busy = (k < n); end
      OP_SRA, OP_SRAI: begin e.res = 32'($signed(a) >>> n);  e.busy = (k < n); end
      OP_LUI:  e.res = x;
      OP_JAL:  begin e.res = x; e.taken = 1'b1; e.tgt = a + b; end
      OP_JALR: begin e.res = x; e.taken = 1'b1; e.tgt = (a + b) & 32'hFFFF_FFFE; end
      OP_BEQ:  begin e.taken = (a == b);                  e.tgt = x; e.rdv = 1'b0; end
      OP_BNE:  begin e.taken = (a != b);                  e.tgt = x; e.rdv = 1'b0; end
      OP_BLT:  begin e.taken = ($signed(a) < $signed(b));  e.tgt = x; e.rdv = 1'b0; end
      OP_BGE:  begin e.taken = ($signed(a) >= $signed(b)); e.tgt = x; e.rdv = 1'b0; end
      OP_BLTU: begin e.taken = (a < b);                   e.tgt = x; e.rdv = 1'b0; end
      OP_BGEU: begin e.taken = (a >= b);                  e.tgt = x; e.rdv = 1'b0; end
      default: ;
    endcase
    if (e.busy) begin
      e.fo  = OP_NOP;
      e.rdv = 1'b0;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // model advances on the same edge as the DUT, from the inputs present at that edge
  always @(posedge clk) begin
    exp_t e;
    e = predict(m_f, m_a, m_b, m_x, m_rdv, m_k);
    if (rst) begin
      m_f = OP_NOP; m_a = '0; m_b = '0; m_x = '0; m_rd = '0; m_rdv = 1'b0; m_k = 0;
    end else if (!stall_in) begin
      if (e.busy) m_k++;
      else begin
        m_f = func_in; m_a = right; m_b = left; m_x = extra;
        m_rd = rd_in; m_rdv = rdv_in; m_k = 0;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (check_en) begin
      e = predict(m_f, m_a, m_b, m_x, m_rdv, m_k);
      chk("busy", 32'(busy), 32'(e.busy));
      chk("func_out", 32'(func_out), 32'(e.fo));
      chk("rdv_out", 32'(rdv_out), 32'(e.rdv));
      chk("rd_out", 32'(rd_out), 32'(m_rd));
      chk("jmp", 32'(jmp), 32'(e.taken & ~stall_in));
      if (e.taken) chk("jmp_target", jmp_target, e.tgt);
      if (!e.busy) chk("result", result, e.res);
    end
  end

  task automatic drv(input logic [5:0] f, input logic [31:0] r, input logic [31:0] l,
                     input logic [31:0] x, input logic [4:0] rd, input logic rdv);
    func_in = f; right = r; left = l; extra = x; rd_in = rd; rdv_in = rdv;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_one(input logic [5:0] f, input logic [31:0] r, input logic [31:0] l,
                          input logic [31:0] x, input logic [4:0] rd, input logic rdv);
    drv(f, r, l, x, rd, rdv);
    tick();
    drv(OP_NOP, '0, '0, '0, '0, 1'b0);
    @(negedge clk);
  endtask

  // counts busy cycles until the result cycle; optionally stalls part-way through
  task automatic run_shift(input int stall_from, input int stall_len, output int bc);
    bc = 0;
    for (int i = 0; i < 80; i++) begin
      if (i > 0) @(negedge clk);
      if (!busy) break;
      bc++;
      tick();
      stall_in = (i >= stall_from) && (i < stall_from + stall_len);
    end
    stall_in = 1'b0;
  endtask

  initial begin
    int bc;
    logic [5:0] f;

    repeat (2) tick();
    check_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_jmp", 32'(jmp), 32'd0);
    chk("rst_target", jmp_target, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_func_out", 32'(func_out), 32'(OP_NOP));
    chk("rst_rd_out", 32'(rd_out), 32'd0);
    chk("rst_rdv_out", 32'(rdv_out), 32'd0);
    rst = 1'b0;

    load_one(OP_ADD, 32'd7, 32'hFFFF_FFFD, '0, 5'd3, 1'b1);
    chk("add_result", result, 32'd4);
    chk("add_rdv", 32'(rdv_out), 32'd1);
    chk("add_jmp", 32'(jmp), 32'd0);

    load_one(OP_SLTU, 32'd1, 32'hFFFF_FFFF, '0, 5'd4, 1'b1);
    chk("sltu_result", result, 32'd1);

    load_one(OP_BNE, 32'd5, 32'd6, 32'h100, 5'd0, 1'b0);
    chk("bne_jmp", 32'(jmp), 32'd1);
    chk("bne_target", jmp_target, 32'h100);
    chk("bne_rdv", 32'(rdv_out), 32'd0);
    @(negedge clk);
    chk("bne_jmp_once", 32'(jmp), 32'd0);

    load_one(OP_BEQ, 32'd5, 32'd6, 32'h100, 5'd0, 1'b0);
    chk("beq_jmp", 32'(jmp), 32'd0);

    load_one(OP_JALR, 32'h203, 32'd4, 32'h44, 5'd1, 1'b1);
    chk("jalr_target", jmp_target, 32'h206);
    chk("jalr_result", result, 32'h44);

    load_one(OP_SRA, 32'h8000_0000, 32'd4, '0, 5'd7, 1'b1);
    run_shift(99, 0, bc);
    chk("sra_busy_cycles", 32'(bc), 32'd4);
    chk("sra_result", result, 32'hF800_0000);
    chk("sra_rdv", 32'(rdv_out), 32'd1);

    load_one(OP_SLL, 32'h1234, 32'h20, '0, 5'd2, 1'b1);
    chk("sll0_busy", 32'(busy), 32'd0);
    chk("sll0_result", result, 32'h1234);

    load_one(OP_SLLI, 32'h8000_0001, 32'd1, '0, 5'd2, 1'b1);
    run_shift(99, 0, bc);
    chk("sll1_busy_cycles", 32'(bc), 32'd1);
    chk("sll1_result", result, 32'h0000_0002);

    load_one(OP_SRA, 32'h8000_0000, 32'd4, '0, 5'd7, 1'b1);
    run_shift(1, 3, bc);
    chk("stall_busy_cycles", 32'(bc), 32'd7);
    chk("stall_result", result, 32'hF800_0000);

    load_one(OP_SRL, 32'hFFFF_FFFF, 32'd10, '0, 5'd9, 1'b1);
    chk("srl_busy", 32'(busy), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_func_out", 32'(func_out), 32'(OP_NOP));
    chk("rstmid_rdv", 32'(rdv_out), 32'd0);
    chk("rstmid_jmp", 32'(jmp), 32'd0);

    repeat (3000) begin
      f = 6'($urandom_range(0, 39));
      drv(f, $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) left[4:0] = 5'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) right = left;
      stall_in = ($urandom_range(0, 4) == 0);
      rst      = ($urandom_range(0, 199) == 0);
      tick();
    end

    drv(OP_NOP, '0, '0, '0, '0, 1'b0);
    stall_in = 1'b0;
    rst = 1'b0;
    repeat (40) tick();
    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
